pa_idu_ld_wb_buf: RTL

- Load-writeback buffer that sits directly upstream of the per-GPR register cells in the IDU.
- Accepts load results from the LSU writeback stage and queues them in a small in-order FIFO.
- Drives write port 1 of the GPR file: one-hot write enables, ICG gate enables, forward enables and write data.
- Holds queued writes while ifu_idu_warm_up owns the whole register file, so no load result is lost or overwritten by the warm-up broadcast.

---
 rtl/pa_idu_ld_wb_buf.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pa_idu_ld_wb_buf.sv
// Load-writeback buffer feeding GPR write port 1; in-order FIFO that holds during warm-up.
// Optional same-cycle bypass when empty: define PA_IDU_LD_WB_BYPASS_EN.
module pa_idu_ld_wb_buf #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic                     lsu_idu_wb_vld,
    input  logic [IDX_W-1:0]         lsu_idu_wb_idx,
    input  logic [DATA_W-1:0]        lsu_idu_wb_data,
    output logic                     idu_lsu_wb_rdy,
    input  logic                     ifu_idu_warm_up,
    output logic [31:0]              reg_write_en1_x,
    output logic [31:0]              reg_write_en_gate1_x,
    output logic [31:0]              reg_fwd_en1_x,
    output logic [DATA_W-1:0]        write_data1,
    output logic                     ld_wb_empty,
    output logic [$clog2(DEPTH):0]   ld_wb_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              push_fifo;
    logic              pop;
    logic              byp;
    logic [IDX_W-1:0]  head_idx;
    logic [DATA_W-1:0] head_data;
    logic              head_vld;
    logic [31:0]       wr_en;
    logic [DATA_W-1:0] wr_data;

    // Bit 0 is never written: x0 is hard-wired zero.
    function automatic logic [31:0] idx2oh(input logic [IDX_W-1:0] idx);
        logic [31:0] oh;
        oh    = 32'd1 << idx;
        oh[0] = 1'b0;
        return oh;
    endfunction

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign head_idx  = idx_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign head_vld  = vld_q[rd_ptr_q];

    assign idu_lsu_wb_rdy = ~full;
    assign ld_wb_empty    = empty;
    assign ld_wb_cnt      = cnt_q;

    assign push = lsu_idu_wb_vld & ~full;
    assign pop  = ~empty & head_vld & ~ifu_idu_warm_up;

`ifdef PA_IDU_LD_WB_BYPASS_EN
    assign byp = empty & ~ifu_idu_warm_up & lsu_idu_wb_vld & ~cpurst;
`else
    assign byp = 1'b0;
`endif

    assign push_fifo = push & ~byp;

    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        if (pop) begin
            wr_en   = idx2oh(head_idx);
            wr_data = head_data;
        end
`ifdef PA_IDU_LD_WB_BYPASS_EN
        else if (byp) begin
            wr_en   = idx2oh(lsu_idu_wb_idx);
            wr_data = lsu_idu_wb_data;
        end
`endif
    end

    assign reg_write_en1_x      = wr_en;
    assign reg_write_en_gate1_x = wr_en;
    assign reg_fwd_en1_x        = wr_en;
    assign write_data1          = wr_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_fifo) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_fifo, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Valid bits are set on enqueue and cleared on drain, so a mid-drain reset drops everything.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
            end
            if (push_fifo) begin
                vld_q[wr_ptr_q]  <= 1'b1;
                idx_q[wr_ptr_q]  <= lsu_idu_wb_idx;
                data_q[wr_ptr_q] <= lsu_idu_wb_data;
            end
        end
    end

endmodule
